// File: rtl/sweep_meter.sv
// Ping-pong sweep meter shared by the angle and strength selectors.
// It bounces a value between MIN_VAL and MAX_VAL on each tick until the player locks it.
module sweep_meter #(
    parameter int WIDTH   = 8,
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 90,
    parameter int STEP    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             lock,
    input  logic             clear,
    input  logic             tick,
    output logic             count_en,
    output logic [WIDTH-1:0] value,
    output logic             dir,
    output logic             sweeping,
    output logic             locked
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SWEEP  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [WIDTH:0]   STEP_W = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0]   MAX_W  = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]   MIN_W  = (WIDTH+1)'(MIN_VAL);
    localparam logic [WIDTH-1:0] MIN_V  = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX_VAL);

    state_t           state_r, state_s;
    logic [WIDTH-1:0] value_r, value_s;
    logic             dir_r, dir_s;
    logic             lock_d_r;
    logic             lock_rise_s;
    logic             count_en_r, sweeping_r, locked_r;
    logic [WIDTH:0]   up_sum_s, dn_sum_s;

    assign lock_rise_s = lock & ~lock_d_r;
    // One guard bit so the top clamp sees overflow and the bottom clamp sees a negative result.
    assign up_sum_s    = {1'b0, value_r} + STEP_W;
    assign dn_sum_s    = {1'b0, value_r} - STEP_W;

    // Next-state and next-value decode; clear outranks everything except reset.
    always_comb begin
        state_s = state_r;
        value_s = value_r;
        dir_s   = dir_r;
        if (clear) begin
            state_s = ST_IDLE;
            value_s = MIN_V;
            dir_s   = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_s = ST_SWEEP;
                        value_s = MIN_V;
                        dir_s   = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_SWEEP: begin
                    if (lock_rise_s) begin
                        state_s = ST_LOCKED;
                    end else if (tick) begin
                        if (dir_r) begin
                            if (up_sum_s >= MAX_W) begin
                                value_s = MAX_V;
                                dir_s   = 1'b0;
                            end else begin
                                value_s = up_sum_s[WIDTH-1:0];
                            end
                        end else begin
                            if ($signed(dn_sum_s) <= $signed(MIN_W)) begin
                                value_s = MIN_V;
                                dir_s   = 1'b1;
                            end else begin
                                value_s = dn_sum_s[WIDTH-1:0];
                            end
                        end
                    end else begin
                        state_s = ST_SWEEP;
                    end
                end
                ST_LOCKED: begin
                    if (start) begin
                        state_s = ST_SWEEP;
                        value_s = MIN_V;
                        dir_s   = 1'b1;
                    end else begin
                        state_s = ST_LOCKED;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    value_s = MIN_V;
                    dir_s   = 1'b1;
                end
            endcase
        end
    end

    // State, value and flag registers; flags are registered copies of the next-state decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            value_r    <= MIN_V;
            dir_r      <= 1'b1;
            lock_d_r   <= 1'b0;
            count_en_r <= 1'b0;
            sweeping_r <= 1'b0;
            locked_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            value_r    <= value_s;
            dir_r      <= dir_s;
            lock_d_r   <= lock;
            count_en_r <= (state_s == ST_SWEEP);
            sweeping_r <= (state_s == ST_SWEEP);
            locked_r   <= (state_s == ST_LOCKED);
        end
    end

    assign count_en = count_en_r;
    assign sweeping = sweeping_r;
    assign locked   = locked_r;
    assign value    = value_r;
    assign dir      = dir_r;

endmodule

// File: tb/tb_sweep_meter.sv
// Directed bench for sweep_meter: a STEP=1 instance for start/lock/clear/reset behaviour
// and a STEP=4 instance for the clamping at both ends of the sweep.
module tb_sweep_meter;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_a, lock_a, clear_a, tick_a;
    logic       start_b, lock_b, clear_b, tick_b;
    logic       count_en_a, dir_a, sweeping_a, locked_a;
    logic       count_en_b, dir_b, sweeping_b, locked_b;
    logic [7:0] value_a, value_b;

    int n_cmp = 0;
    int n_err = 0;

    sweep_meter #(.WIDTH(8), .MIN_VAL(0), .MAX_VAL(90), .STEP(1)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .lock(lock_a), .clear(clear_a),
        .tick(tick_a), .count_en(count_en_a), .value(value_a), .dir(dir_a),
        .sweeping(sweeping_a), .locked(locked_a)
    );

    sweep_meter #(.WIDTH(8), .MIN_VAL(0), .MAX_VAL(90), .STEP(4)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .lock(lock_b), .clear(clear_b),
        .tick(tick_b), .count_en(count_en_b), .value(value_b), .dir(dir_b),
        .sweeping(sweeping_b), .locked(locked_b)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n clock edges; outputs are sampled 1 time unit after the edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick_a_once();
        tick_a = 1'b1;
        cyc(1);
        tick_a = 1'b0;
    endtask

    task automatic tick_b_once();
        tick_b = 1'b1;
        cyc(1);
        tick_b = 1'b0;
    endtask

    task automatic check_a(input string tag, input int v, input int d, input int sw, input int lk);
        check_eq({tag, ".value"},    32'(value_a),    32'(v));
        check_eq({tag, ".dir"},      32'(dir_a),      32'(d));
        check_eq({tag, ".sweeping"}, 32'(sweeping_a), 32'(sw));
        check_eq({tag, ".count_en"}, 32'(count_en_a), 32'(sw));
        check_eq({tag, ".locked"},   32'(locked_a),   32'(lk));
    endtask

    initial begin
        reset = 1'b1;
        {start_a, lock_a, clear_a, tick_a} = 4'b0000;
        {start_b, lock_b, clear_b, tick_b} = 4'b0000;
        cyc(2);
        check_a("reset", 0, 1, 0, 0);
        reset = 1'b0;
        cyc(1);

        // Idle ignores tick and lock.
        tick_a = 1'b1; lock_a = 1'b1;
        cyc(1);
        tick_a = 1'b0; lock_a = 1'b0;
        cyc(1);
        check_a("idle_ignore", 0, 1, 0, 0);

        start_a = 1'b1;
        cyc(1);
        start_a = 1'b0;
        check_a("start", 0, 1, 1, 0);
        for (int i = 1; i <= 5; i++) begin
            tick_a_once();
            check_eq("up_step", 32'(value_a), 32'(i));
        end
        cyc(3);
        check_eq("hold_no_tick", 32'(value_a), 32'd5);

        // Run up to 37, then lock with a coincident tick.
        repeat (32) tick_a_once();
        check_eq("at_37", 32'(value_a), 32'd37);
        lock_a = 1'b1; tick_a = 1'b1;
        cyc(1);
        lock_a = 1'b0; tick_a = 1'b0;
        check_a("lock", 37, 1, 0, 1);
        repeat (3) begin
            tick_a_once();
            lock_a = 1'b1;
            cyc(1);
            lock_a = 1'b0;
            cyc(1);
        end
        check_a("locked_frozen", 37, 1, 0, 1);

        // Restart from LOCKED.
        start_a = 1'b1;
        cyc(1);
        start_a = 1'b0;
        check_a("restart", 0, 1, 1, 0);

        // Lock held through entry to SWEEP must not lock until re-pressed.
        clear_a = 1'b1;
        cyc(1);
        clear_a = 1'b0;
        check_a("clear_to_idle", 0, 1, 0, 0);
        lock_a = 1'b1;
        cyc(1);
        start_a = 1'b1;
        cyc(1);
        start_a = 1'b0;
        cyc(2);
        check_a("lock_held", 0, 1, 1, 0);
        lock_a = 1'b0;
        cyc(1);
        check_a("lock_release", 0, 1, 1, 0);
        lock_a = 1'b1;
        cyc(1);
        lock_a = 1'b0;
        check_a("lock_repress", 0, 1, 0, 1);

        // Clear mid-sweep at 50, with a tick in the same cycle.
        start_a = 1'b1;
        cyc(1);
        start_a = 1'b0;
        repeat (50) tick_a_once();
        check_eq("at_50", 32'(value_a), 32'd50);
        clear_a = 1'b1; tick_a = 1'b1;
        cyc(1);
        clear_a = 1'b0; tick_a = 1'b0;
        check_a("clear_sweep", 0, 1, 0, 0);

        // Reset mid-sweep.
        start_a = 1'b1;
        cyc(1);
        start_a = 1'b0;
        repeat (3) tick_a_once();
        check_eq("at_3", 32'(value_a), 32'd3);
        reset = 1'b1; tick_a = 1'b1;
        cyc(1);
        reset = 1'b0; tick_a = 1'b0;
        check_a("reset_mid", 0, 1, 0, 0);

        // STEP=4 instance: top clamp then bottom clamp.
        cyc(1);
        start_b = 1'b1;
        cyc(1);
        start_b = 1'b0;
        check_eq("b_start.value", 32'(value_b), 32'd0);
        check_eq("b_start.sweeping", 32'(sweeping_b), 32'd1);
        for (int k = 1; k <= 22; k++) begin
            tick_b_once();
            check_eq("b_up.value", 32'(value_b), 32'(4 * k));
            check_eq("b_up.dir", 32'(dir_b), 32'd1);
        end
        tick_b_once();
        check_eq("b_top.value", 32'(value_b), 32'd90);
        check_eq("b_top.dir", 32'(dir_b), 32'd0);
        for (int k = 1; k <= 22; k++) begin
            tick_b_once();
            check_eq("b_dn.value", 32'(value_b), 32'(90 - 4 * k));
            check_eq("b_dn.dir", 32'(dir_b), 32'd0);
        end
        tick_b_once();
        check_eq("b_bot.value", 32'(value_b), 32'd0);
        check_eq("b_bot.dir", 32'(dir_b), 32'd1);
        tick_b_once();
        check_eq("b_rebound.value", 32'(value_b), 32'd4);
        check_eq("b_rebound.dir", 32'(dir_b), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sweep_meter.md
Name: sweep_meter

Overview:
- Downstream consumer of the 0.05 s tick counter.
- Shared by the angle and strength selectors: ping-pongs a value between MIN_VAL and MAX_VAL, one STEP per tick, until the player locks it.
- Drives the counter's enable, so ticks run only while sweeping.
- Locked value feeds the launch/physics logic.

Parameters:
WIDTH, 8, bit width of value
MIN_VAL, 0, lower sweep bound (inclusive)
MAX_VAL, 90, upper sweep bound (inclusive)
STEP, 1, increment per tick
- Legal range: MIN_VAL < MAX_VAL < 2^WIDTH; 1 <= STEP <= MAX_VAL-MIN_VAL.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  level; begins a sweep from IDLE or LOCKED
lock  input  1  player button, level; its rising edge freezes the value
clear  input  1  synchronous return to IDLE
tick  input  1  one-cycle pulse from the counter's next output
count_en  output  1  drives the counter's enable input
value  output  WIDTH  current meter value
dir  output  1  1 = rising, 0 = falling
sweeping  output  1  high in SWEEP
locked  output  1  high in LOCKED

Behaviour:
- One clock. Reset is synchronous and active-high; ports are named clk and reset. All state is updated on posedge clk.
- Reset values: state IDLE, value = MIN_VAL, dir = 1, count_en = 0, sweeping = 0, locked = 0, lock_d = 0.
- States are IDLE, SWEEP and LOCKED. Outputs are Moore outputs, decoded from registered state only:
  - count_en = sweeping = (state == SWEEP)
  - locked = (state == LOCKED)
- Priority, highest first: reset > clear > lock edge > tick > start.
- Edge detect: lock_d <= lock every cycle; lock_rise = lock & ~lock_d.
- IDLE:
  - start = 1 -> SWEEP next cycle; value <= MIN_VAL, dir <= 1.
  - lock and tick are ignored.
- SWEEP:
  - lock_rise -> LOCKED; value and dir hold. A tick in the same cycle is discarded.
  - Else on tick with dir = 1: compute value+STEP in WIDTH+1 bits.
    - If >= MAX_VAL: value <= MAX_VAL, dir <= 0.
    - Otherwise value <= value+STEP.
  - Else on tick with dir = 0: compute value-STEP in WIDTH+1 bits (signed compare, no underflow wrap).
    - If <= MIN_VAL: value <= MIN_VAL, dir <= 1.
    - Otherwise value <= value-STEP.
  - start is ignored. No tick means value holds.
- LOCKED:
  - value and dir frozen; count_en = 0.
  - start = 1 -> SWEEP, value <= MIN_VAL, dir <= 1 (restart).
  - Further lock edges and ticks are ignored.
- clear in any state -> IDLE, value <= MIN_VAL, dir <= 1.
- Latency:
  - start to count_en high: 1 cycle.
  - tick to value update: 1 cycle.
  - lock edge to locked high: 1 cycle.
- Counter interaction: count_en drops when leaving SWEEP, which zeroes the counter's internal delay. Each re-entry to SWEEP therefore waits a full tick period before the first step.
- Lock already high on entry to SWEEP: no lock_rise. The button must be released and pressed again to lock.
- Endpoints are emitted exactly once per turn: MAX_VAL is followed by MAX_VAL-STEP, never a repeat.

Test Plan:
- Reset, then start=1 for 1 cycle -> next cycle sweeping=1, count_en=1, value=0, dir=1. 5 ticks (STEP=1) -> value=5.
- Clamp at top: STEP=4, MAX_VAL=90, sweep up from 0 -> values 0,4,…,88, then 90 with dir=0, then 86.
- Clamp at bottom: STEP=4, falling from 6 -> 2 -> 0 with dir=1 -> 4. value never wraps to 254.
- Lock: lock rises at value=37, with tick in the same cycle -> locked=1, value stays 37, count_en=0. Further ticks and lock pulses leave value at 37.
- Lock held high across start -> stays SWEEP. Release, then re-press -> LOCKED on the 2nd press.
- clear during SWEEP at value=50 -> IDLE, value=0, count_en=0. start from LOCKED -> SWEEP with value=0, dir=1. reset asserted mid-sweep -> all outputs at their reset values next cycle.
